// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared types and helpers for the pipeline hazard controller
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // MEM wins over WB because it holds the younger value of the register.
  function automatic fwd_sel_e fwd_pick(
    input logic [4:0] rs,
    input logic       mem_wr,
    input logic [4:0] mem_rd,
    input logic       wb_wr,
    input logic [4:0] wb_rd
  );
    if (mem_wr && mem_rd != REG_X0 && mem_rd == rs) return FWD_MEM;
    if (wb_wr && wb_rd != REG_X0 && wb_rd == rs) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/mdu_stall_timer.sv
// rtl/mdu_stall_timer.sv - MDU wait down-counter with done flag
module mdu_stall_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] mcnt,
  output logic       done
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt <= 4'd0;
    end else if (load) begin
      mcnt <= load_val;
    end else if (dec) begin
      mcnt <= mcnt - 4'd1;
    end
  end

  assign done = (mcnt == 4'd1);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forwarding control for a five-stage pipeline
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_wr,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_wr,
  input  logic             wb_reg_wr,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             bubble_mem,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam bit         MDU_STALLS = (MDU_LAT > 1);
  localparam bit         MDU_WAITS  = (MDU_LAT > 2);
  localparam logic [3:0] MDU_RELOAD = 4'(MDU_LAT - 2);

  hz_state_e  state, next_state;
  logic       lu;
  logic       t_load, t_dec, t_done;
  logic [3:0] mcnt;
  logic       s_if, s_id, s_ex, f_id, f_ex, b_mem, busy;

  assign lu = ex_is_load && ex_reg_wr && (ex_rd != REG_X0) &&
              ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));

  mdu_stall_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (MDU_RELOAD),
    .dec      (t_dec),
    .mcnt     (mcnt),
    .done     (t_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    s_if   = 1'b0;
    s_id   = 1'b0;
    s_ex   = 1'b0;
    f_id   = 1'b0;
    f_ex   = 1'b0;
    b_mem  = 1'b0;
    busy   = 1'b0;
    t_load = 1'b0;
    t_dec  = 1'b0;
    case (state)
      RUN: begin
        if (ex_branch_taken) begin
          f_id = 1'b1;
          f_ex = 1'b1;
        end else if (ex_mdu_start && MDU_STALLS) begin
          s_if   = 1'b1;
          s_id   = 1'b1;
          s_ex   = 1'b1;
          b_mem  = 1'b1;
          busy   = 1'b1;
          t_load = 1'b1;
          next_state = MDU_WAITS ? MDU_WAIT : RUN;
        end else if (lu) begin
          s_if = 1'b1;
          s_id = 1'b1;
          f_ex = 1'b1;
        end
      end
      MDU_WAIT: begin
        // EX holds the MDU op, so branch/start/load-use inputs are stale here.
        s_if  = 1'b1;
        s_id  = 1'b1;
        s_ex  = 1'b1;
        b_mem = 1'b1;
        busy  = 1'b1;
        if (t_done) next_state = RUN;
        else        t_dec = 1'b1;
      end
      default: next_state = RUN;
    endcase
  end

  assign stall_if   = s_if  & ~rst;
  assign stall_id   = s_id  & ~rst;
  assign stall_ex   = s_ex  & ~rst;
  assign flush_id   = f_id  & ~rst;
  assign flush_ex   = f_ex  & ~rst;
  assign bubble_mem = b_mem & ~rst;
  assign mdu_busy   = busy  & ~rst;
  assign fwd_a = rst ? FWD_RF : fwd_pick(ex_rs1, mem_reg_wr, mem_rd, wb_reg_wr, wb_rd);
  assign fwd_b = rst ? FWD_RF : fwd_pick(ex_rs2, mem_reg_wr, mem_rd, wb_reg_wr, wb_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if) stall_cnt <= stall_cnt + 1'b1;
      if (flush_id) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_reg_wr, ex_is_load;
  logic       ex_branch_taken, ex_mdu_start, mem_reg_wr, wb_reg_wr;

  logic       stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem, mdu_busy;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cnt, flush_cnt;

  logic       s1_stall_if, s1_stall_id, s1_stall_ex, s1_flush_id, s1_flush_ex;
  logic       s1_bubble_mem, s1_mdu_busy;
  logic [1:0] s1_fwd_a, s1_fwd_b;
  logic [3:0] s1_stall_cnt, s1_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
    .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_wr(mem_reg_wr), .wb_reg_wr(wb_reg_wr),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .flush_ex(flush_ex), .bubble_mem(bubble_mem),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.MDU_LAT(1), .CNT_W(4)) dut_lat1 (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
    .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_wr(mem_reg_wr), .wb_reg_wr(wb_reg_wr),
    .stall_if(s1_stall_if), .stall_id(s1_stall_id), .stall_ex(s1_stall_ex),
    .flush_id(s1_flush_id), .flush_ex(s1_flush_ex), .bubble_mem(s1_bubble_mem),
    .fwd_a(s1_fwd_a), .fwd_b(s1_fwd_b), .mdu_busy(s1_mdu_busy),
    .stall_cnt(s1_stall_cnt), .flush_cnt(s1_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_reg_wr = 1'b0; ex_is_load = 1'b0;
    ex_branch_taken = 1'b0; ex_mdu_start = 1'b0;
    mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_wr = 1'b0; wb_reg_wr = 1'b0;
  endtask

  task automatic set_lu();
    ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    check("rst_stall_if", 32'(stall_if), 32'd0);
    set_lu();
    ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_wr = 1'b1;
    #1;
    check("rst_lu_forced", 32'(stall_if | flush_ex), 32'd0);
    check("rst_fwd_forced", 32'(fwd_a), 32'd0);
    clear_inputs();
    tick();
    rst = 1'b0;
    #1;

    // MDU timing, latency 4: stall t0..t2, released t3
    ex_mdu_start = 1'b1;
    #1;
    check("mdu_t0_ctrl", {28'd0, stall_if, stall_ex, bubble_mem, mdu_busy}, 32'hF);
    check("mdu_lat1_no_stall", {30'd0, s1_stall_if, s1_mdu_busy}, 32'd0);
    tick();
    ex_mdu_start = 1'b0;
    ex_branch_taken = 1'b1;
    #1;
    check("mdu_t1_ctrl", {29'd0, stall_ex, bubble_mem, mdu_busy}, 32'h7);
    check("mdu_t1_branch_ignored", {30'd0, flush_id, flush_ex}, 32'd0);
    check("lat1_branch_flush", 32'(s1_flush_id), 32'd1);
    tick();
    ex_branch_taken = 1'b0;
    #1;
    check("mdu_t2_ctrl", {29'd0, stall_ex, bubble_mem, mdu_busy}, 32'h7);
    tick();
    check("mdu_t3_ctrl", {29'd0, stall_ex, bubble_mem, mdu_busy}, 32'd0);
    check("mdu_stall_cnt", 32'(stall_cnt), 32'd3);
    check("mdu_flush_cnt", 32'(flush_cnt), 32'd0);

    // Reset in the middle of an MDU wait
    ex_mdu_start = 1'b1;
    tick();
    ex_mdu_start = 1'b0;
    #1;
    check("mdu_wait_busy", 32'(mdu_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_ctrl", {29'd0, stall_if, mdu_busy, bubble_mem}, 32'd0);
    check("rst_mid_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_stall_if", 32'(stall_if), 32'd0);
    tick();
    check("post_rst_run", {30'd0, stall_if, mdu_busy}, 32'd0);

    // Load-use
    set_lu();
    #1;
    check("lu_ctrl", {27'd0, stall_if, stall_id, flush_ex, stall_ex, flush_id}, 32'b11100);
    tick();
    clear_inputs();
    #1;
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    check("lu_one_cycle", 32'(stall_if), 32'd0);
    set_lu();
    ex_rd = 5'd0; id_rs2 = 5'd0;
    #1;
    check("lu_x0_no_stall", 32'(stall_if), 32'd0);
    set_lu();
    id_uses_rs2 = 1'b0;
    #1;
    check("lu_unused_src", 32'(stall_if), 32'd0);
    id_uses_rs1 = 1'b1; id_rs1 = 5'd5;
    #1;
    check("lu_rs1", 32'(stall_id), 32'd1);
    clear_inputs();

    // Branch beats load-use
    set_lu();
    ex_branch_taken = 1'b1;
    #1;
    check("br_over_lu", {29'd0, flush_id, flush_ex, stall_if}, 32'b110);
    tick();
    clear_inputs();
    #1;
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt), 32'd1);

    // Forwarding
    mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_wr = 1'b1; wb_reg_wr = 1'b1;
    ex_rs1 = 5'd7; ex_rs2 = 5'd3;
    #1;
    check("fwd_a_mem", 32'(fwd_a), 32'd1);
    check("fwd_b_none", 32'(fwd_b), 32'd0);
    ex_rs2 = 5'd7;
    #1;
    check("fwd_b_mem", 32'(fwd_b), 32'd1);
    mem_reg_wr = 1'b0;
    #1;
    check("fwd_a_wb", 32'(fwd_a), 32'd2);
    ex_rs1 = 5'd0;
    #1;
    check("fwd_a_x0", 32'(fwd_a), 32'd0);
    wb_rd = 5'd0;
    #1;
    check("fwd_a_wb_x0", 32'(fwd_a), 32'd0);
    clear_inputs();

    // Counter wrap with CNT_W=4
    do_reset();
    set_lu();
    for (int i = 0; i < 17; i++) tick();
    clear_inputs();
    #1;
    check("stall_cnt_wrap", 32'(stall_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the five-stage RISC-V pipeline registers: PC, IF/ID, ID/EX, EX/MEM (ALU result buffer) and MEM/WB.
- Generates stall (hold) and flush (bubble) controls for load-use hazards, taken branches and multi-cycle MDU operations.
- Produces EX-stage operand forwarding selects.
- Keeps free-running stall and flush performance counters.

Parameters:
- MDU_LAT, 4, MDU latency in cycles; legal range 1..15; 1 means single-cycle, so no MDU stall.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX
- ex_rd  in  5  destination register of the EX instruction
- ex_reg_wr  in  1  EX instruction writes rd
- ex_is_load  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- ex_mdu_start  in  1  EX instruction is an MDU op; first EX cycle only
- mem_rd, wb_rd  in  5 each  destination registers in MEM and WB
- mem_reg_wr, wb_reg_wr  in  1 each  write enables in MEM and WB
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID
- stall_ex  out  1  hold ID/EX
- flush_id  out  1  load bubble into IF/ID
- flush_ex  out  1  load bubble into ID/EX
- bubble_mem  out  1  load zero/bubble into EX/MEM (ALU buffer)
- fwd_a, fwd_b  out  2 each  operand select: 00 register file, 01 MEM, 10 WB
- mdu_busy  out  1  MDU stall in progress
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- States: RUN, MDU_WAIT. Down-counter mcnt is 4 bits.
- Reset (asynchronous, active-high):
  - state=RUN, mcnt=0, stall_cnt=0, flush_cnt=0.
  - While rst=1, every control output is forced to 0: stall_*, flush_*, bubble_mem, mdu_busy, fwd_a=fwd_b=00.
  - Reset asserted in MDU_WAIT aborts the wait; the pipeline resumes in RUN.
- Load-use hazard: lu = ex_is_load & ex_reg_wr & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN priority, highest first:
  - 1) ex_branch_taken: flush_id=1, flush_ex=1, no stalls. Overrides lu because the ID instruction is squashed.
  - 2) ex_mdu_start & MDU_LAT>1: stall_if=stall_id=stall_ex=1, bubble_mem=1, mdu_busy=1, mcnt<=MDU_LAT-2. Next state is MDU_WAIT if MDU_LAT>2, otherwise RUN.
  - 3) lu: stall_if=stall_id=1, flush_ex=1, for one cycle. It re-asserts only if the condition persists.
  - 4) Otherwise all controls are 0.
- MDU_WAIT:
  - stall_if=stall_id=stall_ex=1, bubble_mem=1, mdu_busy=1.
  - If mcnt==1, next state is RUN; otherwise mcnt decrements.
  - ex_branch_taken, ex_mdu_start and lu are ignored here; the EX stage holds the MDU op.
- Total MDU stall length is exactly MDU_LAT-1 cycles, counting the start cycle. The instruction after the MDU op enters EX in cycle MDU_LAT.
- Forwarding is combinational, with MEM taking priority over WB:
  - fwd_a=01 if mem_reg_wr & mem_rd!=0 & mem_rd==ex_rs1.
  - Else fwd_a=10 if wb_reg_wr & wb_rd!=0 & wb_rd==ex_rs1.
  - Else fwd_a=00.
  - fwd_b is the same using ex_rs2.
- Registers x0 never cause a hazard or a forward.
- Counters:
  - stall_cnt increments in every cycle with stall_if=1.
  - flush_cnt increments in every cycle with flush_id=1.
  - Both wrap modulo 2^CNT_W with no saturation.
- Latency: all control outputs are combinational from the current state and inputs; zero cycles.

Decomposition:
- Package riscv_pipe_pkg holds:
  - fwd_sel_e enum: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - hz_state_e enum: RUN, MDU_WAIT.
  - REG_X0=5'd0.
- One natural sub-module, mdu_stall_timer: the mcnt load/decrement with a done flag.
- Forwarding and load-use detection stay inline.

Test Plan:
- Reset mid-MDU-wait: MDU_LAT=4; ex_mdu_start pulse at t0; rst high at t1 -> all outputs 0 during reset; state RUN and stall_if=0 after release.
- Load-use: ex_is_load=1, ex_reg_wr=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> stall_if=stall_id=flush_ex=1 for that cycle; stall_cnt increments by 1. With ex_rd=0 -> no stall.
- Branch beats load-use: lu condition true and ex_branch_taken=1 simultaneously -> flush_id=flush_ex=1, stall_if=0; flush_cnt increments by 1.
- MDU timing:
  - MDU_LAT=4, ex_mdu_start at t0 -> stall_ex, bubble_mem and mdu_busy are 1 in t0..t2 and 0 in t3; ex_branch_taken=1 at t1 is ignored.
  - MDU_LAT=1 -> no stall.
- Forwarding:
  - mem_rd=wb_rd=7, both writing, ex_rs1=7 -> fwd_a=01.
  - mem_reg_wr=0 -> fwd_a=10.
  - ex_rs1=0 -> fwd_a=00.
- Counter wrap: CNT_W=4, hold lu for 17 cycles -> stall_cnt reads 1.
